// File: rtl/ofdm_symbol_sequencer_if.sv
// ofdm_symbol_sequencer_if: sample, FFT-control, slicer and decision bundle of the OFDM symbol sequencer
//   in_valid/in_ready                      sample handshake from the front end
//   fft_start/fft_done                     FFT start pulse and completion pulse
//   bin_rd/bin_addr/slice_data             slicer read strobe, bin index, result one cycle later
//   out_valid/out_ready/out_bits/out_last  decision stream to the demapper
//   sym_count/pilot_ok                     completed-symbol count and fixed-tone status
//   modport master: the sequencer; modport slave: its surroundings
interface ofdm_symbol_sequencer_if #(parameter int N_FFT = 128);
  logic in_valid, in_ready, fft_start, fft_done, bin_rd;
  logic [$clog2(N_FFT)-1:0] bin_addr;
  logic [1:0] slice_data, out_bits;
  logic out_valid, out_ready, out_last, pilot_ok;
  logic [15:0] sym_count;
  modport master(
    input in_valid, fft_done, slice_data, out_ready,
    output in_ready, fft_start, bin_rd, bin_addr, out_valid, out_bits, out_last, sym_count, pilot_ok
  );
  modport slave(
    output in_valid, fft_done, slice_data, out_ready,
    input in_ready, fft_start, bin_rd, bin_addr, out_valid, out_bits, out_last, sym_count, pilot_ok
  );
endinterface

// File: rtl/ofdm_symbol_sequencer.sv
// ofdm_symbol_sequencer: per-symbol control of sample loading, FFT start/wait and slicer bin walk
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  ofdm_symbol_sequencer_if.master: sample handshake, FFT start/done, slicer read, decision stream,
//        sym_count and pilot_ok
//   PILOT_CHECK_EN  when defined, PILOT_BIN_A/B are read after the data bins and pilot_ok reports both == 2'b11
module ofdm_symbol_sequencer #(
  parameter int N_FFT = 128,
  parameter int FIRST_BIN = 4,
  parameter int LAST_BIN = 55,
  parameter int PILOT_BIN_A = 57,
  parameter int PILOT_BIN_B = 59
) (
  input logic clk,
  input logic rst,
  ofdm_symbol_sequencer_if.master bus
);
  localparam int AW = $clog2(N_FFT);
  localparam logic [AW-1:0] CNT_MAX = AW'(N_FFT - 1);
  localparam logic [AW-1:0] BIN_FIRST = AW'(FIRST_BIN);
  localparam logic [AW-1:0] BIN_LAST = AW'(LAST_BIN);
  localparam logic [AW-1:0] BIN_PA = AW'(PILOT_BIN_A);
  localparam logic [AW-1:0] BIN_PB = AW'(PILOT_BIN_B);
  typedef enum logic [3:0] {IDLE, LOAD, START, WAIT, RD, LAT, OUT, PRD, PLAT, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0] cnt, bin;
  logic [1:0] bits;
  logic [15:0] sym;
  logic pok, take, hs, last_bin, pil_last, pil_pass;
  assign take = bus.in_valid && state == LOAD;
  assign hs = bus.out_ready && state == OUT;
  assign last_bin = bin == BIN_LAST;
`ifdef PILOT_CHECK_EN
  localparam state_t AFTER_DATA = PRD;
  logic [1:0] pil_a, pil_b;
  logic pil_sel;
  // pil_sel picks which tone the current PLAT captures; cleared by every decision handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pil_a <= '0;
      pil_b <= '0;
      pil_sel <= 1'b0;
    end else if (hs) begin
      pil_sel <= 1'b0;
    end else if (state == PLAT) begin
      pil_sel <= 1'b1;
      if (pil_sel) pil_b <= bus.slice_data;
      else pil_a <= bus.slice_data;
    end
  assign pil_last = pil_sel;
  assign pil_pass = pil_a == 2'b11 && pil_b == 2'b11;
`else
  localparam state_t AFTER_DATA = DONE;
  assign pil_last = 1'b1;
  assign pil_pass = 1'b1;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = LOAD;
      LOAD: state_n = take && cnt == CNT_MAX ? START : LOAD;
      START: state_n = WAIT;
      WAIT: state_n = bus.fft_done ? RD : WAIT;
      RD: state_n = LAT;
      LAT: state_n = OUT;
      OUT: state_n = !hs ? OUT : last_bin ? AFTER_DATA : RD;
      PRD: state_n = PLAT;
      PLAT: state_n = pil_last ? DONE : PRD;
      DONE: state_n = LOAD;
      default: state_n = IDLE;
    endcase
  end
  // bin walks FIRST..LAST, then parks on the pilot tones (only read when the pilot phase exists)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bin <= '0;
      bits <= '0;
      sym <= '0;
      pok <= 1'b0;
    end else begin
      state <= state_n;
      if (take) cnt <= cnt == CNT_MAX ? '0 : cnt + 1'b1;
      if (state == WAIT && bus.fft_done) bin <= BIN_FIRST;
      else if (hs) bin <= last_bin ? BIN_PA : bin + 1'b1;
      else if (state == PLAT) bin <= BIN_PB;
      if (state == LAT) bits <= bus.slice_data;
      if (state == DONE) begin
        sym <= sym + 1'b1;
        pok <= pil_pass;
      end
    end
  assign bus.in_ready = state == LOAD;
  assign bus.fft_start = state == START;
  assign bus.bin_rd = state == RD || state == PRD;
  assign bus.bin_addr = bin;
  assign bus.out_valid = state == OUT;
  assign bus.out_bits = bits;
  assign bus.out_last = state == OUT && last_bin;
  assign bus.sym_count = sym;
  assign bus.pilot_ok = pok;
endmodule

// File: tb/tb_ofdm_symbol_sequencer.sv
// tb_ofdm_symbol_sequencer: randomized scoreboard bench for ofdm_symbol_sequencer
module tb_ofdm_symbol_sequencer;
  localparam int N_FFT = 128;
  localparam int FIRST = 4;
  localparam int LAST = 55;
  localparam int PA = 57;
  localparam int PB = 59;
`ifdef PILOT_CHECK_EN
  localparam int DONE_LAT = 6;
`else
  localparam int DONE_LAT = 2;
`endif
  logic clk = 0;
  logic rst = 1;
  ofdm_symbol_sequencer_if #(.N_FFT(N_FFT)) bus();
  ofdm_symbol_sequencer #(.N_FFT(N_FFT), .FIRST_BIN(FIRST), .LAST_BIN(LAST), .PILOT_BIN_A(PA), .PILOT_BIN_B(PB))
    dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, passed = 0;
  logic [1:0] mem [N_FFT];
  logic [2:0] exp_q[$];
  int rd_q[$];
  logic pok_exp = 1'b0;
  int accepted = 0, start_due = -1, start_seen = 0, rd_due = -1, ov_due = -1, done_due = -1;
  int done_seen = 0, hs_in_sym = 0, sym_model = 0;
  bit ov_pend = 0;
  int iv_mode = 1;
  bit or_rand = 0, spur_en = 0, real_req = 0;
  int stall_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic miss(input string name);
    total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  initial begin
    bus.in_valid = 0;
    bus.out_ready = 1;
    bus.fft_done = 0;
    bus.slice_data = 0;
  end
  initial forever begin
    @(posedge clk); #1;
    bus.in_valid = iv_mode == 1 ? 1'b1 : iv_mode == 2 ? 1'b0 : ($urandom_range(0, 3) != 0);
  end
  initial forever begin
    @(posedge clk); #1;
    if (stall_left > 0 && hs_in_sym == 16 && bus.out_valid) begin
      bus.out_ready = 0;
      stall_left--;
    end else bus.out_ready = or_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end
  // Real completion pulses come from real_req; stray pulses only while the sequencer is loading or presenting
  initial forever begin
    @(posedge clk); #1;
    bus.fft_done = 0;
    if (real_req) begin
      bus.fft_done = 1;
      real_req = 0;
      rd_due = cyc + 1;
    end else if (spur_en && (bus.in_ready || bus.out_valid) && $urandom_range(0, 4) == 0) bus.fft_done = 1;
  end
  // Slicer model: answers a read one cycle later from the current symbol's bin table
  initial begin
    logic rp;
    logic [6:0] ap;
    forever begin
      @(negedge clk);
      rp = bus.bin_rd;
      ap = bus.bin_addr;
      @(posedge clk); #1;
      if (rp) bus.slice_data = mem[ap];
    end
  end

  always @(negedge clk) if (!rst) begin
    logic [2:0] e;
    int a;
    if (bus.in_valid && bus.in_ready) begin
      accepted++;
      if (accepted % N_FFT == 0) start_due = cyc + 1;
    end
    if (bus.fft_start) begin
      chk("fft_start_cycle", cyc, start_due);
      start_due = -1;
      start_seen++;
    end
    if (bus.bin_rd) begin
      if (rd_q.size() == 0) miss("bin_rd_unexpected");
      else begin
        a = rd_q.pop_front();
        chk("bin_addr", 32'(bus.bin_addr), a);
        chk("bin_rd_cycle", cyc, rd_due);
        if (a <= LAST) ov_due = cyc + 2;
        else rd_due = cyc + 2;
      end
    end
    if (bus.out_valid) begin
      if (!ov_pend) begin
        chk("out_valid_cycle", cyc, ov_due);
        ov_pend = 1;
      end
      if (exp_q.size() == 0) miss("out_valid_unexpected");
      else begin
        chk("out_bits", 32'(bus.out_bits), 32'(exp_q[0][2:1]));
        chk("out_last", 32'(bus.out_last), 32'(exp_q[0][0]));
        if (bus.out_ready) begin
          e = exp_q.pop_front();
          ov_pend = 0;
          rd_due = cyc + 1;
          hs_in_sym++;
          if (e[0]) begin
            done_due = cyc + DONE_LAT;
            hs_in_sym = 0;
            sym_model++;
          end
        end
      end
    end
    if (cyc == done_due - 1) chk("in_ready_in_done", 32'(bus.in_ready), 0);
    if (cyc == done_due) begin
      chk("in_ready_after_done", 32'(bus.in_ready), 1);
      chk("sym_count", 32'(bus.sym_count), 32'(sym_model[15:0]));
      chk("pilot_ok", 32'(bus.pilot_ok), 32'(pok_exp));
      done_seen++;
      done_due = -1;
    end
  end

  task automatic check_reset_outputs();
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_fft_start", 32'(bus.fft_start), 0);
    chk("rst_bin_rd", 32'(bus.bin_rd), 0);
    chk("rst_bin_addr", 32'(bus.bin_addr), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_bits", 32'(bus.out_bits), 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_sym_count", 32'(bus.sym_count), 0);
    chk("rst_pilot_ok", 32'(bus.pilot_ok), 0);
  endtask
  task automatic release_reset();
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 0);
    @(negedge clk);
    chk("in_ready_rise", 32'(bus.in_ready), 1);
  endtask

  task automatic run_symbol(input bit rnd, input logic [1:0] pa, input logic [1:0] pb, input int dly,
                            input bit abort, output bit ok);
    int base, t;
    ok = 1;
    for (int b = 0; b < N_FFT; b++) mem[b] = rnd ? 2'($urandom_range(0, 3)) : 2'(b);
    mem[PA] = pa;
    mem[PB] = pb;
    for (int b = FIRST; b <= LAST; b++) begin
      exp_q.push_back({mem[b], b == LAST});
      rd_q.push_back(b);
    end
`ifdef PILOT_CHECK_EN
    rd_q.push_back(PA);
    rd_q.push_back(PB);
    pok_exp = pa == 2'b11 && pb == 2'b11;
`else
    pok_exp = 1'b1;
`endif
    base = start_seen;
    t = 0;
    while (start_seen == base && t < 4000) begin @(negedge clk); t++; end
    if (start_seen == base) begin miss("timeout_fft_start"); ok = 0; return; end
    repeat (dly) @(negedge clk);
    real_req = 1;
    if (abort) begin
      t = 0;
      while (!(bus.bin_rd && bus.bin_addr == 7'd30) && t < 2000) begin @(negedge clk); t++; end
      if (t >= 2000) begin miss("timeout_bin30"); ok = 0; return; end
      #2 rst = 1;
      #1 check_reset_outputs();
      exp_q.delete();
      rd_q.delete();
      accepted = 0; start_due = -1; rd_due = -1; ov_due = -1; done_due = -1;
      hs_in_sym = 0; sym_model = 0; ov_pend = 0; stall_left = 0;
      repeat (2) @(negedge clk);
      release_reset();
      return;
    end
    base = done_seen;
    t = 0;
    while (done_seen == base && t < 5000) begin @(negedge clk); t++; end
    if (done_seen == base) begin miss("timeout_symbol_done"); ok = 0; end
  endtask

  function automatic logic [1:0] rnd_pilot();
    return $urandom_range(0, 1) != 0 ? 2'b11 : 2'($urandom_range(0, 3));
  endfunction

  initial begin
    bit ok;
    ok = 1;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    release_reset();
    run_symbol(0, 2'b11, 2'b11, 4, 0, ok);
    if (ok) begin
      stall_left = 10;
      run_symbol(1, 2'b11, 2'b01, 2, 0, ok);
    end
    if (ok) begin
      iv_mode = 0; or_rand = 1; spur_en = 1;
      run_symbol(1, rnd_pilot(), rnd_pilot(), $urandom_range(0, 8), 0, ok);
      spur_en = 0;
    end
    if (ok) run_symbol(1, rnd_pilot(), rnd_pilot(), $urandom_range(0, 8), 1, ok);
    for (int k = 0; k < 2 && ok; k++) run_symbol(1, rnd_pilot(), rnd_pilot(), $urandom_range(0, 8), 0, ok);
    if (ok) begin
      iv_mode = 2;
      repeat (20) @(negedge clk);
      chk("fft_start_total", start_seen, 6);
      chk("in_ready_idle_load", 32'(bus.in_ready), 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
